// File: rtl/out_buf_drain_arbiter.sv
// Pointer owner and round-robin drain of NCH single-reader output RAMs onto one valid/ready stream.
// Define OUT_ARB_STATS_EN to add per-channel drained_cnt handoff counters (cleared by clr_ovf).
module out_buf_drain_arbiter #(
   parameter int NCH = 3,
   parameter int AW  = 12,
   parameter int DW  = 32
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NCH-1:0]           wr_en,
   output logic [NCH*AW-1:0]        wr_addr,
   output logic [NCH-1:0]           rd_en,
   output logic [NCH*AW-1:0]        rd_addr,
   input  logic [NCH*DW-1:0]        ram_q,
   input  logic                     enable,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DW-1:0]            out_data,
   output logic [$clog2(NCH)-1:0]   out_chan,
   output logic [NCH-1:0]           empty,
   output logic [NCH-1:0]           full,
   output logic [NCH-1:0]           overflow,
   input  logic                     clr_ovf
`ifdef OUT_ARB_STATS_EN
   ,
   output logic [NCH*32-1:0]        drained_cnt
`endif
);

   localparam int CW = $clog2(NCH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      VALID = 2'd3
   } state_t;

   state_t          state_reg, state_next;
   logic [CW-1:0]   grant_reg, grant_next;
   logic [CW-1:0]   last_grant_reg;
   logic [CW-1:0]   rr_pick;
   logic            rr_found;
   int              rr_idx;
   logic [DW-1:0]   sel_q;
   logic [DW-1:0]   out_data_reg;
   logic [CW-1:0]   out_chan_reg;
   logic            handoff;

   assign out_valid = (state_reg == VALID);
   assign out_data  = out_data_reg;
   assign out_chan  = out_chan_reg;
   assign handoff   = out_valid && out_ready;

   // Round-robin search starts just after the channel served last.
   always_comb begin
      rr_pick  = last_grant_reg;
      rr_found = 1'b0;
      rr_idx   = 0;
      for (int k = 1; k <= NCH; k++) begin
         rr_idx = (int'(last_grant_reg) + k) % NCH;
         if (!rr_found && !empty[rr_idx]) begin
            rr_found = 1'b1;
            rr_pick  = CW'(rr_idx);
         end
      end
   end

   always_comb begin
      sel_q = '0;
      for (int k = 0; k < NCH; k++) begin
         if (grant_reg == CW'(k)) begin
            sel_q = ram_q[k*DW +: DW];
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      grant_next = grant_reg;
      case (state_reg)
         IDLE: begin
            if (enable && rr_found) begin
               state_next = ISSUE;
               grant_next = rr_pick;
            end
         end
         ISSUE:   state_next = WAIT;
         WAIT:    state_next = VALID;
         VALID: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= IDLE;
         grant_reg      <= '0;
         last_grant_reg <= CW'(NCH - 1);
         out_data_reg   <= '0;
         out_chan_reg   <= '0;
      end else begin
         state_reg <= state_next;
         grant_reg <= grant_next;
         if (state_reg == ISSUE) begin
            last_grant_reg <= grant_reg;
         end
         if (state_reg == WAIT) begin
            out_data_reg <= sel_q;
            out_chan_reg <= grant_reg;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         logic [AW:0] wp_reg;
         logic [AW:0] rp_reg;
         logic [AW:0] occ;
         logic        ovf_reg;
         logic        take;

         // Pointers carry one extra wrap bit so full and empty stay distinguishable.
         assign occ         = wp_reg - rp_reg;
         assign empty[gi]   = (occ == '0);
         assign full[gi]    = occ[AW];
         assign take        = (state_reg == ISSUE) && (grant_reg == CW'(gi));
         assign rd_en[gi]   = take;
         assign overflow[gi] = ovf_reg;
         assign wr_addr[gi*AW +: AW] = wp_reg[AW-1:0];
         assign rd_addr[gi*AW +: AW] = rp_reg[AW-1:0];

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               wp_reg  <= '0;
               ovf_reg <= 1'b0;
            end else begin
               if (wr_en[gi] && !full[gi]) begin
                  wp_reg <= wp_reg + 1'b1;
               end
               if (clr_ovf) begin
                  ovf_reg <= 1'b0;
               end else if (wr_en[gi] && full[gi]) begin
                  ovf_reg <= 1'b1;
               end
            end
         end

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               rp_reg <= '0;
            end else if (take) begin
               rp_reg <= rp_reg + 1'b1;
            end
         end

`ifdef OUT_ARB_STATS_EN
         logic [31:0] cnt_reg;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               cnt_reg <= '0;
            end else if (clr_ovf) begin
               cnt_reg <= '0;
            end else if (handoff && (out_chan_reg == CW'(gi))) begin
               cnt_reg <= cnt_reg + 32'd1;
            end
         end

         assign drained_cnt[gi*32 +: 32] = cnt_reg;
`endif
      end
   endgenerate

`ifndef OUT_ARB_STATS_EN
   logic unused_handoff;
   assign unused_handoff = handoff;
`endif

endmodule

// File: tb/tb_out_buf_drain_arbiter.sv
// Self-checking bench for out_buf_drain_arbiter: attached RAM model, queue-based reference model,
// directed steps plus randomized write/ready traffic. Handles OUT_ARB_STATS_EN builds.
module tb_out_buf_drain_arbiter;
   localparam int NCH   = 3;
   localparam int AW    = 12;
   localparam int DW    = 32;
   localparam int DEPTH = 4096;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [NCH-1:0]    wr_en;
   logic [NCH*AW-1:0] wr_addr;
   logic [NCH-1:0]    rd_en;
   logic [NCH*AW-1:0] rd_addr;
   logic [NCH*DW-1:0] ram_q;
   logic              enable;
   logic              out_valid;
   logic              out_ready;
   logic [DW-1:0]     out_data;
   logic [1:0]        out_chan;
   logic [NCH-1:0]    empty;
   logic [NCH-1:0]    full;
   logic [NCH-1:0]    overflow;
   logic              clr_ovf;
`ifdef OUT_ARB_STATS_EN
   logic [NCH*32-1:0] drained_cnt;
`endif

   logic [31:0] wr_data [NCH];
   logic [31:0] mem [NCH][DEPTH];

   int tests = 0;
   int fails = 0;
   logic rand_ready = 1'b0;

   // Reference model: per-channel FIFO contents, last served channel, sticky overflow.
   logic [31:0] mdata [NCH][8192];
   int          mhead [NCH];
   int          mtail [NCH];
   int          mlast;
   logic [2:0]  movf;
   logic [33:0] exp_q [$];
   logic [33:0] mon_e;

   always #5 clk = ~clk;

   out_buf_drain_arbiter #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .ram_q     (ram_q),
      .enable    (enable),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_chan  (out_chan),
      .empty     (empty),
      .full      (full),
      .overflow  (overflow),
      .clr_ovf   (clr_ovf)
`ifdef OUT_ARB_STATS_EN
      ,
      .drained_cnt (drained_cnt)
`endif
   );

   // Output RAMs: write on wr_en, registered read on rd_en.
   always @(posedge clk) begin
      for (int i = 0; i < NCH; i++) begin
         if (wr_en[i]) mem[i][wr_addr[i*AW +: AW]] <= wr_data[i];
         if (rd_en[i]) ram_q[i*DW +: DW] <= mem[i][rd_addr[i*AW +: AW]];
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic int model_occ(input int c);
      return mtail[c] - mhead[c];
   endfunction

   function automatic logic [63:0] model_empty();
      logic [2:0] r;
      for (int c = 0; c < NCH; c++) r[c] = (model_occ(c) == 0);
      return 64'(r);
   endfunction

   function automatic logic [63:0] model_full();
      logic [2:0] r;
      for (int c = 0; c < NCH; c++) r[c] = (model_occ(c) == DEPTH);
      return 64'(r);
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         mhead[c] = 0;
         mtail[c] = 0;
      end
      mlast = NCH - 1;
      movf  = '0;
      exp_q.delete();
   endtask

   task automatic model_write(input int c, input logic [31:0] d);
      if (model_occ(c) < DEPTH) begin
         mdata[c][mtail[c] % 8192] = d;
         mtail[c]++;
      end else begin
         movf[c] = 1'b1;
      end
   endtask

   // With no writes during the drain, the output order is fully determined by round-robin.
   task automatic model_predict_drain();
      int c;
      while (model_occ(0) + model_occ(1) + model_occ(2) > 0) begin
         for (int k = 1; k <= NCH; k++) begin
            c = (mlast + k) % NCH;
            if (model_occ(c) > 0) begin
               exp_q.push_back({2'(c), mdata[c][mhead[c] % 8192]});
               mhead[c]++;
               mlast = c;
               break;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic write_one(input int c, input logic [31:0] d);
      wr_en     = '0;
      wr_en[c]  = 1'b1;
      wr_data[c] = d;
      model_write(c, d);
      tick();
      wr_en = '0;
   endtask

   task automatic write_mask(input logic [2:0] mask);
      for (int c = 0; c < NCH; c++) begin
         if (mask[c]) begin
            wr_data[c] = $urandom;
            model_write(c, wr_data[c]);
         end
      end
      wr_en = mask;
      tick();
      wr_en = '0;
   endtask

   task automatic drain(input int budget);
      enable = 1'b1;
      for (int i = 0; i < budget; i++) begin
         if (exp_q.size() == 0) break;
         tick();
      end
      enable = 1'b0;
      check("drain_done", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      repeat (6) tick();
      check("drain_out_valid", 64'(out_valid), 64'd0);
      check("drain_empty", 64'(empty), model_empty());
      check("drain_full", 64'(full), model_full());
   endtask

   always @(negedge clk) begin
      if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_word", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            mon_e = exp_q.pop_front();
            check("out_data", 64'(out_data), 64'(mon_e[31:0]));
            check("out_chan", 64'(out_chan), 64'(mon_e[33:32]));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int c0;
      int c1;
      int n;
      int cyc;
      logic [31:0] d;
      logic [2:0]  exp_rd;
      logic        seen;

      wr_en = '0; enable = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
      for (int i = 0; i < NCH; i++) wr_data[i] = '0;
      model_reset();
      reset_n = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      tick();

      // Reset state
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_chan", 64'(out_chan), 64'd0);
      check("rst_empty", 64'(empty), 64'd7);
      check("rst_full", 64'(full), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
      check("rst_rd_en", 64'(rd_en), 64'd0);
      check("rst_wr_addr", 64'(wr_addr), 64'd0);
      check("rst_rd_addr", 64'(rd_addr), 64'd0);

      // Enabled with nothing written: nothing must happen
      enable = 1'b1;
      repeat (100) begin
         tick();
         check("idle_out_valid", 64'(out_valid), 64'd0);
         check("idle_rd_en", 64'(rd_en), 64'd0);
         check("idle_empty", 64'(empty), 64'd7);
      end
      enable = 1'b0;

      // Directed RR stream A0(0), B0(1), C0(2), A1(0) and grant-to-valid latency
      out_ready = 1'b1;
      write_one(0, 32'hA0);
      write_one(0, 32'hA1);
      write_one(1, 32'hB0);
      write_one(2, 32'hC0);
      model_predict_drain();
      enable = 1'b1;
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      check("latency", 64'(lat), 64'd3);
      drain(200);

      // Randomized multi-channel rounds with random consumer back-pressure
      rand_ready = 1'b1;
      for (int r = 0; r < 6; r++) begin
         n = $urandom_range(1, 8);
         for (int i = 0; i < n; i++) write_mask(3'($urandom_range(1, 7)));
         model_predict_drain();
         drain(1000);
      end
      rand_ready = 1'b0;

      // Consumer stall: word held stable, no new grant, then the pulse releases the next grant
      out_ready = 1'b0;
      c0 = (mlast + 1) % NCH;
      c1 = (mlast + 2) % NCH;
      write_one(c0, 32'h55);
      write_one(c1, 32'h66);
      model_predict_drain();
      enable = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
      end
      check("stall_reach_valid", 64'(seen), 64'd1);
      repeat (20) begin
         tick();
         check("stall_out_valid", 64'(out_valid), 64'd1);
         check("stall_out_data", 64'(out_data), 64'h55);
         check("stall_out_chan", 64'(out_chan), 64'(c0));
         check("stall_rd_en", 64'(rd_en), 64'd0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      exp_rd = '0;
      exp_rd[c1] = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (rd_en != 0) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      check("stall_next_grant", 64'(rd_en), 64'(exp_rd));
      out_ready = 1'b1;
      drain(100);

      // Fill channel 1 to the brim, then overflow and clear
      enable = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) write_one(1, 32'(i));
      check("fill_full", 64'(full), model_full());
      check("fill_overflow", 64'(overflow), 64'(movf));
      write_one(1, 32'hDEAD);
      check("ovf_set", 64'(overflow), 64'(movf));
      check("ovf_wr_addr1", 64'(wr_addr[AW +: AW]), 64'(mtail[1] % DEPTH));
      check("ovf_full", 64'(full), model_full());
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      movf = '0;
      check("ovf_clear", 64'(overflow), 64'd0);
      clr_ovf = 1'b1;
      write_one(1, 32'hBEEF);
      clr_ovf = 1'b0;
      movf = '0;
      check("ovf_clear_wins", 64'(overflow), 64'd0);

      // Reset while the word fetched from channel 1 is in WAIT
      enable = 1'b1;
      out_ready = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (rd_en != 0) begin
            seen = 1'b1;
            break;
         end
      end
      check("pre_reset_issue", 64'(rd_en), 64'd2);
      tick();
      reset_n = 1'b0;
      #1;
      model_reset();
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_wr_addr", 64'(wr_addr), 64'd0);
      check("midrst_rd_addr", 64'(rd_addr), 64'd0);
      check("midrst_empty", 64'(empty), model_empty());
      check("midrst_full", 64'(full), model_full());
      check("midrst_rd_en", 64'(rd_en), 64'd0);
      enable = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      write_one(2, $urandom);
      write_one(1, $urandom);
      write_one(0, $urandom);
      model_predict_drain();
      exp_rd = '0;
      exp_rd[exp_q[0][33:32]] = 1'b1;
      enable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (rd_en != 0) break;
      end
      check("post_reset_grant", 64'(rd_en), 64'(exp_rd));
      drain(200);

      // Pointer wrap on channel 2 with concurrent writing and draining
      out_ready = 1'b1;
      enable = 1'b1;
      n = 0;
      cyc = 0;
      while (n < 5000 && cyc < 40000) begin
         if ($urandom_range(0, 4) == 0) begin
            d = $urandom;
            exp_q.push_back({2'd2, d});
            wr_data[2] = d;
            wr_en = 3'b100;
            n++;
         end else begin
            wr_en = '0;
         end
         tick();
         cyc++;
      end
      wr_en = '0;
      mlast = 2;
      check("wrap_write_count", 64'(n), 64'd5000);
      drain(4000);
      check("wrap_empty_ch2", 64'(empty[2]), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
